// File: rtl/mc_ram_write_ctrl_pkg.sv
// Shared constants and FSM state type for the ram1 write/read sequencer.
package mc_ram_write_ctrl_pkg;

    localparam int BYTES_PER_WORD = 8;
    localparam int WORD_W         = 64;
    localparam int IDX_W          = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_WAIT  = 2'd3
    } state_t;

endpackage

// File: rtl/mc_ram_write_ctrl_if.sv
// Host byte bus plus the single user read port of the RAM sequencer.
interface mc_ram_write_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              byte_valid;
    logic [7:0]        byte_in;
    logic              frame_start;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [63:0]       rd_data;

    // Byte source and read requester
    modport master (
        output byte_valid, byte_in, frame_start, rd_req, rd_addr,
        input  rd_ack, rd_data
    );

    // Sequencer side
    modport slave (
        input  byte_valid, byte_in, frame_start, rd_req, rd_addr,
        output rd_ack, rd_data
    );
endinterface

// File: rtl/mc_ram_write_ctrl_packer.sv
// Packs the CM byte stream MSB-first into 64-bit words. word_done/word_out are
// combinational so the sequencer can launch the write on the edge that takes the 8th byte.
module mc_ram_write_ctrl_packer
    import mc_ram_write_ctrl_pkg::*;
(
    input  logic              CLK_inter,
    input  logic              RST,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    input  logic              frame_start,
    output logic [WORD_W-1:0] word_out,
    output logic              word_done
);
    logic [WORD_W-1:0] word_reg;
    logic [IDX_W-1:0]  idx_reg;

    // A byte on frame_start is always byte 0, so it can never complete a word
    assign word_done = byte_valid && !frame_start && (idx_reg == IDX_W'(BYTES_PER_WORD - 1));
    assign word_out  = {word_reg[WORD_W-9:0], byte_in};

    // Shift register and byte index; 3-bit index wraps 7 -> 0 on the completing byte
    always_ff @(posedge CLK_inter) begin
        if (RST) begin
            word_reg <= '0;
            idx_reg  <= '0;
        end else if (frame_start) begin
            word_reg <= byte_valid ? {{(WORD_W-8){1'b0}}, byte_in} : '0;
            idx_reg  <= byte_valid ? IDX_W'(1) : '0;
        end else if (byte_valid) begin
            word_reg <= word_out;
            idx_reg  <= idx_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mc_ram_write_ctrl.sv
// Sequences ram1: commits packed words at an auto-incrementing address and
// arbitrates the user read port against host writes (writes always win).
module mc_ram_write_ctrl
    import mc_ram_write_ctrl_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1,
    parameter int WRAP   = 0
) (
    input  logic               CLK_inter,
    input  logic               RST,
    mc_ram_write_ctrl_if.slave bus,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_wr_en,
    output logic [WORD_W-1:0]  ram_data_in,
    input  logic [WORD_W-1:0]  ram_data_out,
    output logic [ADDR_W-1:0]  wr_ptr,
    output logic [ADDR_W:0]    word_count,
    output logic               full,
    output logic               overflow
);
    localparam int DEPTH = 1 << ADDR_W;

    state_t            state_reg;
    logic [WORD_W-1:0] pend_word_reg;
    logic              pend_reg;
    logic [3:0]        wait_cnt_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic              ram_wr_en_reg;
    logic [WORD_W-1:0] ram_data_in_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W:0]   word_count_reg;
    logic              overflow_reg;
    logic              rd_ack_reg;
    logic [WORD_W-1:0] rd_data_reg;
    logic [WORD_W-1:0] word_out;
    logic              word_done;
    logic              full_now;

    mc_ram_write_ctrl_packer u_packer (
        .CLK_inter   (CLK_inter),
        .RST         (RST),
        .byte_valid  (bus.byte_valid),
        .byte_in     (bus.byte_in),
        .frame_start (bus.frame_start),
        .word_out    (word_out),
        .word_done   (word_done)
    );

    assign full_now = (word_count_reg == (ADDR_W+1)'(DEPTH));

    // Sequencer FSM: write priority, read issue, read latency wait, registered RAM port
    always_ff @(posedge CLK_inter) begin
        if (RST) begin
            state_reg       <= ST_IDLE;
            pend_word_reg   <= '0;
            pend_reg        <= 1'b0;
            wait_cnt_reg    <= '0;
            ram_addr_reg    <= '0;
            ram_wr_en_reg   <= 1'b0;
            ram_data_in_reg <= '0;
            wr_ptr_reg      <= '0;
            word_count_reg  <= '0;
            overflow_reg    <= 1'b0;
            rd_ack_reg      <= 1'b0;
            rd_data_reg     <= '0;
        end else begin
            ram_wr_en_reg <= 1'b0;
            rd_ack_reg    <= 1'b0;

            // Park a word that completes while the port is busy; 8-byte spacing
            // guarantees it is committed before the next one can arrive
            if (word_done) begin
                pend_reg      <= 1'b1;
                pend_word_reg <= word_out;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (pend_reg || word_done) begin
                        state_reg <= ST_WRITE;
                        pend_reg  <= 1'b0;
                        if (!full_now || (WRAP != 0)) begin
                            ram_wr_en_reg   <= 1'b1;
                            ram_addr_reg    <= wr_ptr_reg;
                            ram_data_in_reg <= pend_reg ? pend_word_reg : word_out;
                            wr_ptr_reg      <= wr_ptr_reg + 1'b1;
                            if (!full_now) begin
                                word_count_reg <= word_count_reg + 1'b1;
                            end
                        end else begin
                            overflow_reg <= 1'b1;
                        end
                    end else if (bus.rd_req) begin
                        state_reg    <= ST_RD_ISSUE;
                        ram_addr_reg <= bus.rd_addr;
                    end
                end
                ST_WRITE: begin
                    state_reg <= ST_IDLE;
                end
                ST_RD_ISSUE: begin
                    state_reg    <= ST_RD_WAIT;
                    wait_cnt_reg <= '0;
                end
                ST_RD_WAIT: begin
                    if (wait_cnt_reg == 4'(RD_LAT - 1)) begin
                        rd_data_reg <= ram_data_out;
                        rd_ack_reg  <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ram_addr    = ram_addr_reg;
    assign ram_wr_en   = ram_wr_en_reg;
    assign ram_data_in = ram_data_in_reg;
    assign wr_ptr      = wr_ptr_reg;
    assign word_count  = word_count_reg;
    assign full        = full_now;
    assign overflow    = overflow_reg;
    assign bus.rd_ack  = rd_ack_reg;
    assign bus.rd_data = rd_data_reg;

endmodule
